// File: rtl/baggage_drop_ctrl.sv
// baggage_drop_ctrl: captures a height sample, takes its 4-bit integer root serially, then drops, rejects as cold, or reports locked.
module baggage_drop_ctrl #(
  parameter int HOLD_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic [7:0] height_i,
  input  logic [3:0] t_lim_i,
  input  logic       drop_en_i,
  output logic       busy_o,
  output logic       done_o,
  output logic [3:0] t_act_o,
  output logic [1:0] status_o,
  output logic       drop_active_o
);
  typedef enum logic [1:0] {IDLE, CALC, DECIDE, DROP} state_t;
  state_t state_q, state_d;
  logic [7:0] height_q, height_d, cnt_q, cnt_d, sq;
  logic [3:0] tlim_q, tlim_d, root_q, root_d, tact_q, tact_d, trial;
  logic [1:0] bit_q, bit_d, status_q, status_d;
  logic       en_q, en_d, done_q, done_d, accept;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      height_q <= '0;
      tlim_q   <= '0;
      en_q     <= 1'b0;
      root_q   <= '0;
      bit_q    <= '0;
      cnt_q    <= '0;
      tact_q   <= '0;
      status_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      height_q <= height_d;
      tlim_q   <= tlim_d;
      en_q     <= en_d;
      root_q   <= root_d;
      bit_q    <= bit_d;
      cnt_q    <= cnt_d;
      tact_q   <= tact_d;
      status_q <= status_d;
      done_q   <= done_d;
    end
  end
  always_comb begin
    state_d = (state_q == IDLE)   ? (start_i ? CALC : IDLE) :
              (state_q == CALC)   ? ((bit_q == 2'd0) ? DECIDE : CALC) :
              (state_q == DECIDE) ? ((en_q && root_q <= tlim_q) ? DROP : IDLE) :
                                    ((!drop_en_i || cnt_q == 8'd0) ? IDLE : DROP);
  end
  // trial fits in 4 bits, so its square never exceeds 225 and 8 bits suffice
  always_comb begin
    accept   = (state_q == IDLE) && start_i;
    trial    = root_q | (4'd1 << bit_q);
    sq       = {4'd0, trial} * {4'd0, trial};
    height_d = accept ? height_i : height_q;
    tlim_d   = accept ? t_lim_i : tlim_q;
    en_d     = accept ? drop_en_i : en_q;
    root_d   = accept ? 4'd0 : (state_q == CALC && sq <= height_q) ? trial : root_q;
    bit_d    = accept ? 2'd3 : (state_q == CALC) ? bit_q - 2'd1 : bit_q;
    tact_d   = accept ? 4'd0 : (state_q == DECIDE) ? root_q : tact_q;
    status_d = accept ? 2'd0 :
               (state_q == DECIDE) ? (!en_q ? 2'd3 : (root_q > tlim_q) ? 2'd1 : 2'd2) :
               (state_q == DROP && !drop_en_i) ? 2'd3 : status_q;
    cnt_d    = (state_q == DECIDE) ? 8'(HOLD_CYCLES - 1) :
               (state_q == DROP && cnt_q != 8'd0) ? cnt_q - 8'd1 : cnt_q;
    done_d   = (state_q != IDLE) && (state_d == IDLE);
  end
  always_comb begin
    busy_o        = state_q != IDLE;
    done_o        = done_q;
    t_act_o       = tact_q;
    status_o      = status_q;
    drop_active_o = state_q == DROP;
  end
endmodule
